// File: rtl/corr_pkg.sv
// Shared definitions for the correlator front-end: sequencer states and loop widths.
// LOOP0_DEFAULT is also used by the signal-delay stage so chunk phasing lines up.
package corr_pkg;

    localparam int LOOP0_DEFAULT = 3;
    localparam int LOOP1_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } seq_state_t;

    // Counter width for a loop of n steps; never narrower than one bit.
    function automatic int cnt_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int ibits(input int loop0);
        return cnt_bits(loop0);
    endfunction

    function automatic int obits(input int loop1);
        return cnt_bits(loop1);
    endfunction

endpackage

// File: rtl/corr_sequencer_loop_counter.sv
// Modulo-COUNT step counter with combinational wrap strobe.
// Latency: count_o updates on the edge after step_i; wrap_o is same-cycle.
// Backpressure: none; clear_i overrides step_i.
module loop_counter
    import corr_pkg::*;
#(
    parameter int COUNT = 3,
    localparam int W = cnt_bits(COUNT)
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clear_i,
    input  logic         step_i,
    output logic [W-1:0] count_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] LAST = W'(COUNT - 1);

    assign wrap_o = step_i && (count_o == LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_o <= '0;
        end else if (clear_i) begin
            count_o <= '0;
        end else if (step_i) begin
            count_o <= (count_o == LAST) ? '0 : count_o + W'(1);
        end
    end

endmodule

// File: rtl/corr_sequencer.sv
// Counts valid sample beats into chunks/windows, drives chain strobes, hands windows to readout.
// Latency: beat/idx/chunk/first/last 1 cycle after the counted valid_i; bank flips 1 cycle after last_o.
// Backpressure: res_valid_o/res_ready_i; an unread window is overwritten and flagged in sticky overflow_o.
module corr_sequencer
    import corr_pkg::*;
#(
    parameter int LOOP0 = LOOP0_DEFAULT,
    parameter int LOOP1 = LOOP1_DEFAULT,
    localparam int IBITS = ibits(LOOP0),
    localparam int OBITS = obits(LOOP1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             valid_i,
    output logic             busy_o,
    output logic [IBITS-1:0] idx_o,
    output logic [OBITS-1:0] chunk_o,
    output logic             beat_o,
    output logic             first_o,
    output logic             last_o,
    output logic             bank_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic             res_bank_o,
    output logic             overflow_o
);

    seq_state_t       state, state_nxt;
    logic             stop_pend, stop_pend_nxt;
    logic             beat;
    logic             cnt_clear;
    logic [IBITS-1:0] in_cnt;
    logic [OBITS-1:0] out_cnt;
    logic             in_wrap;
    logic             win_end;

    assign beat      = (state == RUN) && valid_i;
    assign cnt_clear = (state != RUN);

    loop_counter #(.COUNT(LOOP0)) u_inner (
        .clock   (clock),
        .reset_n (reset_n),
        .clear_i (cnt_clear),
        .step_i  (beat),
        .count_o (in_cnt),
        .wrap_o  (in_wrap)
    );

    loop_counter #(.COUNT(LOOP1)) u_outer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear_i (cnt_clear),
        .step_i  (in_wrap),
        .count_o (out_cnt),
        .wrap_o  (win_end)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            stop_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            stop_pend <= stop_pend_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        stop_pend_nxt = stop_pend;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt     = RUN;
                    stop_pend_nxt = 1'b0;
                end
            end
            RUN: begin
                if (stop_i) begin
                    stop_pend_nxt = 1'b1;
                end
                // A stop on the final beat itself still counts for this window.
                if (win_end && (stop_pend || stop_i)) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (!res_valid_o || res_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_o      <= 1'b0;
            idx_o       <= '0;
            chunk_o     <= '0;
            beat_o      <= 1'b0;
            first_o     <= 1'b0;
            last_o      <= 1'b0;
            bank_o      <= 1'b0;
            res_valid_o <= 1'b0;
            res_bank_o  <= 1'b0;
            overflow_o  <= 1'b0;
        end else begin
            busy_o  <= (state_nxt != IDLE);
            beat_o  <= beat;
            first_o <= beat && (in_cnt == '0) && (out_cnt == '0);
            last_o  <= win_end;
            if (beat) begin
                idx_o   <= in_cnt;
                chunk_o <= out_cnt;
            end
            // Chains tag the last beat with the old bank, so flip only after it has gone out.
            if (last_o) begin
                bank_o <= ~bank_o;
            end
            if (win_end) begin
                res_valid_o <= 1'b1;
                res_bank_o  <= bank_o;
                if (res_valid_o && !res_ready_i) begin
                    overflow_o <= 1'b1;
                end
            end else if (res_valid_o && res_ready_i) begin
                res_valid_o <= 1'b0;
            end
        end
    end

endmodule
